// File: rtl/pe_multifilter_conv_if.sv
// Load and psum stream handshakes for the multi-filter convolution PE.
// The slave modport is the PE; the master modport is whatever feeds and drains it.
interface pe_multifilter_conv_if #(
    parameter int unsigned IFMAP_WIDTH  = 16,
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned PSUM_WIDTH   = 24
);
    logic                    ifmap_valid;
    logic                    ifmap_ready;
    logic [IFMAP_WIDTH-1:0]  ifmap_data;
    logic                    filt_valid;
    logic                    filt_ready;
    logic [FILTER_WIDTH-1:0] filt_data;
    logic                    psum_valid;
    logic                    psum_ready;
    logic [PSUM_WIDTH-1:0]   psum_data;

    modport master (
        output ifmap_valid, ifmap_data, filt_valid, filt_data, psum_ready,
        input  ifmap_ready, filt_ready, psum_valid, psum_data
    );

    modport slave (
        input  ifmap_valid, ifmap_data, filt_valid, filt_data, psum_ready,
        output ifmap_ready, filt_ready, psum_valid, psum_data
    );
endinterface

// File: rtl/pe_multifilter_conv.sv
// 1-D convolution PE: loads one ifmap row and up to MAX_FILT filters, then runs every
// strided output position against every filter through a 2-stage MAC into an output FIFO.
module pe_multifilter_conv #(
    parameter int unsigned IFMAP_WIDTH  = 16,
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned PSUM_WIDTH   = 24,
    parameter int unsigned ROW_MAX      = 32,
    parameter int unsigned FSIZE_MAX    = 8,
    parameter int unsigned MAX_FILT     = 4,
    parameter int unsigned STRIDE_W     = 3,
    parameter int unsigned PSUM_DEPTH   = 8,
    parameter bit          SATURATE     = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [STRIDE_W-1:0]            stride,
    input  logic [$clog2(FSIZE_MAX+1)-1:0] filter_size,
    input  logic [$clog2(MAX_FILT+1)-1:0]  num_filt,
    input  logic [$clog2(ROW_MAX+1)-1:0]   row_len,
    pe_multifilter_conv_if.slave           bus,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);
    localparam int unsigned FS_W   = $clog2(FSIZE_MAX + 1);
    localparam int unsigned NF_W   = $clog2(MAX_FILT + 1);
    localparam int unsigned RL_W   = $clog2(ROW_MAX + 1);
    localparam int unsigned IA_W   = $clog2(ROW_MAX);
    localparam int unsigned TAPS   = MAX_FILT * FSIZE_MAX;
    localparam int unsigned TAP_W  = $clog2(TAPS + 1);
    localparam int unsigned TA_W   = $clog2(TAPS);
    localparam int unsigned PTR_W  = $clog2(PSUM_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PROD_W = IFMAP_WIDTH + FILTER_WIDTH;
    localparam int unsigned WIDE_W = ((PROD_W > PSUM_WIDTH) ? PROD_W : PSUM_WIDTH) + 1;

    typedef enum logic [2:0] {StIdle, StCheck, StLoad, StCompute, StDrain} state_e;

    state_e state_q, state_d;

    // Latched job configuration
    logic [STRIDE_W-1:0] stride_q;
    logic [FS_W-1:0]     fsize_q;
    logic [NF_W-1:0]     nfilt_q;
    logic [RL_W-1:0]     rowlen_q;
    logic [TAP_W-1:0]    total_q;

    // Load and issue counters
    logic [RL_W-1:0]  if_cnt_q;
    logic [TAP_W-1:0] tap_cnt_q;
    logic [FS_W-1:0]  k_q;
    logic [NF_W-1:0]  f_q;
    logic [RL_W-1:0]  pos_q;
    logic [TAP_W-1:0] fbase_q;

    // Scratchpads and output FIFO storage
    logic [IFMAP_WIDTH-1:0]  ifmap_mem [ROW_MAX];
    logic [FILTER_WIDTH-1:0] filt_mem  [TAPS];
    logic [PSUM_WIDTH-1:0]   psum_mem  [PSUM_DEPTH];

    // MAC pipeline
    logic              s1_valid_q, s1_first_q, s1_last_q;
    logic [PROD_W-1:0] s1_prod_q;
    logic [PSUM_WIDTH-1:0] acc_q, acc_next;
    logic                  sat_q, sat_next;

    // FIFO state and psums issued but not yet pushed
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, inflight_q;

    logic cfg_bad, issue, room, k_last, f_last, o_last, grp_start;
    logic push, pop, drain_done, done_set, err_set, done_q, err_q;
    logic if_xfer, ft_xfer;
    logic [IA_W-1:0] ia;
    logic [TA_W-1:0] fa;

    assign cfg_bad = (fsize_q == '0) || (nfilt_q == '0) || (stride_q == '0) ||
                     (32'(rowlen_q) < 32'(fsize_q)) || (32'(rowlen_q) > ROW_MAX) ||
                     (32'(fsize_q) > FSIZE_MAX) || (32'(nfilt_q) > MAX_FILT);

    assign k_last    = (32'(k_q) + 1 == 32'(fsize_q));
    assign f_last    = (32'(f_q) + 1 == 32'(nfilt_q));
    // Last output position: the next stride would run the window past the row
    assign o_last    = (32'(pos_q) + 32'(stride_q) + 32'(fsize_q) > 32'(rowlen_q));
    // A group may start only if a FIFO slot is reserved for every psum already in flight
    assign room      = ((PSUM_DEPTH - 32'(cnt_q)) > 32'(inflight_q));
    assign grp_start = issue && (k_q == '0);
    assign ia        = IA_W'(pos_q) + IA_W'(k_q);
    assign fa        = TA_W'(fbase_q) + TA_W'(k_q);
    assign if_xfer   = bus.ifmap_valid && bus.ifmap_ready;
    assign ft_xfer   = bus.filt_valid && bus.filt_ready;

    assign push       = s1_valid_q && s1_last_q;
    assign pop        = bus.psum_valid && bus.psum_ready;
    assign drain_done = !s1_valid_q && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; start is ignored during the done cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start && !done_q) state_d = StCheck;
            StCheck:   state_d = cfg_bad ? StIdle : StLoad;
            StLoad:    if ((if_cnt_q == rowlen_q) && (tap_cnt_q == total_q)) state_d = StCompute;
            StCompute: if (issue && k_last && f_last && o_last) state_d = StDrain;
            StDrain:   if (drain_done) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: readies depend only on state and counters, never on valid
    always_comb begin
        busy            = (state_q != StIdle);
        bus.ifmap_ready = (state_q == StLoad) && (if_cnt_q < rowlen_q);
        bus.filt_ready  = (state_q == StLoad) && (tap_cnt_q < total_q);
        issue           = (state_q == StCompute) && ((k_q != '0) || room);
        done_set        = ((state_q == StCheck) && cfg_bad) || ((state_q == StDrain) && drain_done);
        err_set         = (state_q == StCheck) && cfg_bad;
    end

    // One-cycle done / cfg_err pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_set;
            err_q  <= err_set;
        end
    end
    assign done    = done_q;
    assign cfg_err = err_q;

    // Configuration is captured only on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
            fsize_q  <= '0;
            nfilt_q  <= '0;
            rowlen_q <= '0;
            total_q  <= '0;
        end else if (state_q == StIdle && start && !done_q) begin
            stride_q <= stride;
            fsize_q  <= filter_size;
            nfilt_q  <= num_filt;
            rowlen_q <= row_len;
        end else if (state_q == StCheck) begin
            total_q <= TAP_W'(32'(fsize_q) * 32'(nfilt_q));
        end
    end

    // Load counters and (o, f, k) issue walk
    always_ff @(posedge clk) begin
        if (rst || state_q == StCheck) begin
            if_cnt_q  <= '0;
            tap_cnt_q <= '0;
            k_q       <= '0;
            f_q       <= '0;
            pos_q     <= '0;
            fbase_q   <= '0;
        end else begin
            if (if_xfer) if_cnt_q <= if_cnt_q + 1'b1;
            if (ft_xfer) tap_cnt_q <= tap_cnt_q + 1'b1;
            if (issue) begin
                if (!k_last) begin
                    k_q <= k_q + 1'b1;
                end else begin
                    k_q <= '0;
                    if (!f_last) begin
                        f_q     <= f_q + 1'b1;
                        fbase_q <= fbase_q + TAP_W'(fsize_q);
                    end else begin
                        f_q     <= '0;
                        fbase_q <= '0;
                        if (!o_last) pos_q <= pos_q + RL_W'(stride_q);
                    end
                end
            end
        end
    end

    // Scratchpad and FIFO storage writes
    always_ff @(posedge clk) begin
        if (if_xfer) ifmap_mem[IA_W'(if_cnt_q)] <= bus.ifmap_data;
        if (ft_xfer) filt_mem[TA_W'(tap_cnt_q)] <= bus.filt_data;
        if (push)    psum_mem[wr_ptr_q] <= acc_next;
    end

    // MAC stage 1: register the product with group-position flags
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
        end else begin
            s1_valid_q <= issue;
            s1_first_q <= (k_q == '0);
            s1_last_q  <= k_last;
            s1_prod_q  <= PROD_W'(ifmap_mem[ia]) * PROD_W'(filt_mem[fa]);
        end
    end

    // MAC stage 2 datapath: width-adjust, add, optionally clamp with a sticky flag
    always_comb begin
        logic [WIDE_W-1:0]     prod_wide;
        logic [PSUM_WIDTH-1:0] base;
        logic [PSUM_WIDTH:0]   sum;
        prod_wide = WIDE_W'(s1_prod_q);
        base      = s1_first_q ? '0 : acc_q;
        sum       = {1'b0, base} + {1'b0, prod_wide[PSUM_WIDTH-1:0]};
        sat_next  = (!s1_first_q && sat_q) || (|(prod_wide >> PSUM_WIDTH)) || sum[PSUM_WIDTH];
        acc_next  = (SATURATE && sat_next) ? '1 : sum[PSUM_WIDTH-1:0];
    end

    // MAC stage 2 accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (s1_valid_q) begin
            acc_q <= acc_next;
            sat_q <= sat_next;
        end
    end

    // FIFO pointers, occupancy and in-flight reservation count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            case ({grp_start, push})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // FIFO head; data forced to zero when empty so reset leaves the bus clean
    always_comb begin
        bus.psum_valid = (cnt_q != '0);
        bus.psum_data  = bus.psum_valid ? psum_mem[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_pe_multifilter_conv.sv
module tb_pe_multifilter_conv;
    localparam int unsigned PW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start;
    logic [2:0] stride;
    logic [3:0] filter_size;
    logic [2:0] num_filt;
    logic [5:0] row_len;
    logic       busy, done, cfg_err;

    logic s_start;
    logic s_busy, s_done, s_err, w_busy, w_done, w_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] sb[$];
    int ifm[32];
    int tap[32];

    pe_multifilter_conv_if #(.IFMAP_WIDTH(16), .FILTER_WIDTH(8), .PSUM_WIDTH(24)) dif ();
    pe_multifilter_conv_if #(.IFMAP_WIDTH(16), .FILTER_WIDTH(8), .PSUM_WIDTH(8))  sif ();
    pe_multifilter_conv_if #(.IFMAP_WIDTH(16), .FILTER_WIDTH(8), .PSUM_WIDTH(8))  wif ();

    pe_multifilter_conv #(.PSUM_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride), .filter_size(filter_size),
        .num_filt(num_filt), .row_len(row_len), .bus(dif), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    pe_multifilter_conv #(.PSUM_WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .stride(3'd1), .filter_size(4'd1),
        .num_filt(3'd1), .row_len(6'd1), .bus(sif), .busy(s_busy), .done(s_done),
        .cfg_err(s_err)
    );

    pe_multifilter_conv #(.PSUM_WIDTH(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .start(s_start), .stride(3'd1), .filter_size(4'd1),
        .num_filt(3'd1), .row_len(6'd1), .bus(wif), .busy(w_busy), .done(w_done),
        .cfg_err(w_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every popped psum must match the oldest expected value
    always @(negedge clk) begin
        if (!rst && dif.psum_valid && dif.psum_ready) begin
            check("psum_expected", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) check("psum_data", 32'(dif.psum_data), 32'(sb.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference convolution pushed onto the scoreboard, position-major, filter-minor
    task automatic model(input int rl, input int s, input int f, input int nf);
        for (int o = 0; o * s + f <= rl; o++)
            for (int fi = 0; fi < nf; fi++) begin
                longint acc = 0;
                for (int k = 0; k < f; k++) acc += longint'(ifm[o * s + k]) * tap[fi * f + k];
                sb.push_back(PW'(acc));
            end
    endtask

    task automatic launch(input int rl, input int s, input int f, input int nf);
        row_len = 6'(rl); stride = 3'(s); filter_size = 4'(f); num_filt = 3'(nf);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_ifmap(input int n);
        for (int i = 0; i < n; i++) begin
            logic got = 1'b0;
            dif.ifmap_valid = 1'b1;
            dif.ifmap_data  = 16'(ifm[i]);
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk); got = dif.ifmap_ready;
                @(posedge clk); #1;
            end
            check("ifmap_accept", 32'(got), 32'd1);
        end
        dif.ifmap_valid = 1'b0;
    endtask

    task automatic feed_filt(input int n);
        for (int i = 0; i < n; i++) begin
            logic got = 1'b0;
            dif.filt_valid = 1'b1;
            dif.filt_data  = 8'(tap[i]);
            for (int c = 0; c < 100 && !got; c++) begin
                @(negedge clk); got = dif.filt_ready;
                @(posedge clk); #1;
            end
            check("filt_accept", 32'(got), 32'd1);
        end
        dif.filt_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic got, output logic err);
        got = 1'b0; err = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; err = cfg_err; end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_job(input string tag, input int rl, input int s, input int f, input int nf);
        logic gd, ge;
        model(rl, s, f, nf);
        launch(rl, s, f, nf);
        fork
            feed_ifmap(rl);
            feed_filt(f * nf);
        join
        wait_done(400, gd, ge);
        check({tag, "_done"}, 32'(gd), 32'd1);
        check({tag, "_cfg_err"}, 32'(ge), 32'd0);
        check({tag, "_all_popped"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_ifmap_ready"}, 32'(dif.ifmap_ready), 32'd0);
        check({tag, "_filt_ready"}, 32'(dif.filt_ready), 32'd0);
        check({tag, "_psum_valid"}, 32'(dif.psum_valid), 32'd0);
        check({tag, "_psum_data"}, 32'(dif.psum_data), 32'd0);
    endtask

    task automatic load_t1;
        for (int i = 0; i < 5; i++) ifm[i] = i + 1;
        for (int i = 0; i < 3; i++) tap[i] = 1;
    endtask

    task automatic load_t2;
        for (int i = 0; i < 7; i++) ifm[i] = i + 1;
        tap[0] = 1; tap[1] = 0; tap[2] = 0; tap[3] = 0; tap[4] = 0; tap[5] = 1;
    endtask

    // Illegal configurations: row_len, stride, filter_size, num_filt
    int bad_cfg[7][4] = '{'{2, 1, 3, 1}, '{5, 0, 3, 1}, '{5, 1, 0, 1}, '{5, 1, 3, 0},
                          '{33, 1, 3, 1}, '{20, 1, 9, 1}, '{20, 1, 3, 5}};

    initial begin
        logic gd, ge;
        logic [7:0] sat_val, wrap_val;
        logic sat_got, wrap_got, sd_seen, wd_seen;

        rst = 1'b1; start = 1'b0; s_start = 1'b0;
        stride = '0; filter_size = '0; num_filt = '0; row_len = '0;
        dif.ifmap_valid = 1'b0; dif.ifmap_data = '0; dif.filt_valid = 1'b0;
        dif.filt_data = '0; dif.psum_ready = 1'b1;
        sif.ifmap_valid = 1'b0; sif.ifmap_data = '0; sif.filt_valid = 1'b0;
        sif.filt_data = '0; sif.psum_ready = 1'b1;
        wif.ifmap_valid = 1'b0; wif.ifmap_data = '0; wif.filt_valid = 1'b0;
        wif.filt_data = '0; wif.psum_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: stride 1, one box filter
        load_t1();
        run_job("t1", 5, 1, 3, 1);

        // Test 2: stride 2, two filters, interleaved output order
        load_t2();
        run_job("t2", 7, 2, 3, 2);

        // Test 3: consumer stalled long enough to fill the 4-deep FIFO
        dif.psum_ready = 1'b0;
        model(7, 2, 3, 2);
        launch(7, 2, 3, 2);
        fork
            feed_ifmap(7);
            feed_filt(6);
        join
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t3_busy_stalled", 32'(busy), 32'd1);
        check("t3_psum_valid", 32'(dif.psum_valid), 32'd1);
        check("t3_head", 32'(dif.psum_data), 32'd1);
        check("t3_none_popped", 32'(sb.size()), 32'd6);
        dif.psum_ready = 1'b1;
        wait_done(400, gd, ge);
        check("t3_done", 32'(gd), 32'd1);
        check("t3_all_popped", 32'(sb.size()), 32'd0);

        // Test 5: reset in the middle of a job with psums sitting in the FIFO
        dif.psum_ready = 1'b0;
        load_t1();
        launch(5, 1, 3, 1);
        fork
            feed_ifmap(5);
            feed_filt(3);
        join
        repeat (6) @(posedge clk);
        #1;
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("t5_reset");
        rst = 1'b0;
        dif.psum_ready = 1'b1;
        @(posedge clk); #1;
        load_t2();
        run_job("t5_rerun", 7, 2, 3, 2);

        // Test 6 and friends: illegal configs end with done+cfg_err, start in done cycle ignored
        for (int i = 0; i < 7; i++) begin
            launch(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3]);
            @(negedge clk);
            check("cfg_check_done_low", 32'(done), 32'd0);
            @(negedge clk);
            check("cfg_done", 32'(done), 32'd1);
            check("cfg_err", 32'(cfg_err), 32'd1);
            check("cfg_readies", 32'({dif.ifmap_ready, dif.filt_ready}), 32'd0);
            check("cfg_psum_valid", 32'(dif.psum_valid), 32'd0);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check("cfg_start_in_done_ignored", 32'(busy), 32'd0);
            check("cfg_done_pulse_once", 32'(done), 32'd0);
            @(posedge clk); #1;
        end

        // Test 4: 255*255 into an 8-bit psum, saturating and wrapping builds
        sif.ifmap_valid = 1'b1; sif.ifmap_data = 16'd255; sif.filt_valid = 1'b1;
        sif.filt_data = 8'd255;
        wif.ifmap_valid = 1'b1; wif.ifmap_data = 16'd255; wif.filt_valid = 1'b1;
        wif.filt_data = 8'd255;
        sat_got = 1'b0; wrap_got = 1'b0; sd_seen = 1'b0; wd_seen = 1'b0;
        sat_val = '0; wrap_val = '0;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int c = 0; c < 60 && !(sd_seen && wd_seen); c++) begin
            @(negedge clk);
            if (sif.psum_valid && !sat_got) begin sat_got = 1'b1; sat_val = sif.psum_data; end
            if (wif.psum_valid && !wrap_got) begin wrap_got = 1'b1; wrap_val = wif.psum_data; end
            if (s_done) sd_seen = 1'b1;
            if (w_done) wd_seen = 1'b1;
        end
        sif.ifmap_valid = 1'b0; sif.filt_valid = 1'b0;
        wif.ifmap_valid = 1'b0; wif.filt_valid = 1'b0;
        check("t4_sat_seen", 32'(sat_got), 32'd1);
        check("t4_sat_value", 32'(sat_val), 32'd255);
        check("t4_wrap_seen", 32'(wrap_got), 32'd1);
        check("t4_wrap_value", 32'(wrap_val), 32'd1);
        check("t4_done", 32'({sd_seen, wd_seen}), 32'd3);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
